// File: rtl/tpu_sequencer.sv
// tpu_sequencer: job sequencer feeding serial operands into the TinyTPU core and draining its serial result.
// Ports:
//   clk, rst (async, active-low)
//   host job:    start, num_steps -> busy, done, err
//   host load:   in_valid, x_bit, y_bit -> in_ready
//   core load:   load_en, data_in_x, data_in_y, init
//   core result: data_out_z, tx_ready -> z_bit, z_valid
module tpu_sequencer #(
  parameter int D_W         = 8,
  parameter int N           = 2,
  parameter int WORD        = 8,
  parameter int STEP_W      = 8,
  parameter int COMPUTE_LAT = 3*N-1,
  parameter int TX_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              x_bit,
  input  logic              y_bit,
  output logic              load_en,
  output logic              data_in_x,
  output logic              data_in_y,
  output logic              init,
  input  logic              data_out_z,
  input  logic              tx_ready,
  output logic              z_bit,
  output logic              z_valid
);
  localparam int LOAD_BITS = N*WORD;
  localparam int OUT_BITS  = N*N*2*D_W;
  localparam int BW = LOAD_BITS   > 1 ? $clog2(LOAD_BITS)   : 1;
  localparam int LW = COMPUTE_LAT > 1 ? $clog2(COMPUTE_LAT) : 1;
  localparam int OW = OUT_BITS    > 1 ? $clog2(OUT_BITS)    : 1;
  localparam int TW = $clog2(TX_TIMEOUT+1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LOAD_BITS-1);
  localparam logic [LW-1:0] LAT_LAST = LW'(COMPUTE_LAT-1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_BITS-1);
  localparam logic [TW-1:0] TMO      = TW'(TX_TIMEOUT);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, WAIT_TX, DONE} state_t;
  state_t state, nxt;
  logic [STEP_W-1:0] steps, step_cnt;
  logic [BW-1:0] bit_cnt;
  logic [LW-1:0] lat_cnt;
  logic [OW-1:0] out_cnt;
  logic [TW-1:0] timer;
  assign load_en   = in_valid & in_ready;
  assign data_in_x = x_bit;
  assign data_in_y = y_bit;
  assign z_bit     = data_out_z;
  // Result bits pass straight through so each core strobe is seen the same cycle.
  assign z_valid   = tx_ready & (state == WAIT_TX);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (num_steps == '0) ? DONE : LOAD;
      LOAD:    if (load_en && bit_cnt == BIT_LAST) nxt = COMPUTE;
      COMPUTE: if (lat_cnt == LAT_LAST) nxt = (step_cnt == steps - 1'b1) ? FLUSH : LOAD;
      FLUSH:   nxt = WAIT_TX;
      WAIT_TX: if ((z_valid && out_cnt == OUT_LAST) || (!tx_ready && timer == TMO)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      in_ready <= 1'b0;
      init     <= 1'b0;
      steps    <= '0;
      step_cnt <= '0;
      bit_cnt  <= '0;
      lat_cnt  <= '0;
      out_cnt  <= '0;
      timer    <= '0;
    end else begin
      state    <= nxt;
      busy     <= nxt != IDLE;
      done     <= nxt == DONE;
      in_ready <= nxt == LOAD;
      init     <= nxt == FLUSH;
      case (state)
        IDLE: if (start) begin
          steps    <= num_steps;
          err      <= 1'b0;
          step_cnt <= '0;
          bit_cnt  <= '0;
        end
        LOAD: if (load_en) begin
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          lat_cnt <= '0;
        end
        COMPUTE: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LAT_LAST) begin
            step_cnt <= step_cnt + 1'b1;
            bit_cnt  <= '0;
          end
        end
        FLUSH: begin
          timer   <= '0;
          out_cnt <= '0;
        end
        WAIT_TX:
          if (tx_ready) begin
            out_cnt <= out_cnt + 1'b1;
            timer   <= '0;
          end else if (timer == TMO) err <= 1'b1;
          else timer <= timer + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: table-driven job checks plus reset and ignored-start sequences for tpu_sequencer.
module tb_tpu_sequencer;
  logic clk, rst, start, busy, done, err, in_valid, in_ready, x_bit, y_bit;
  logic load_en, data_in_x, data_in_y, init, data_out_z, tx_ready, z_bit, z_valid;
  logic [7:0] num_steps;

  tpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .busy(busy), .done(done),
    .err(err), .in_valid(in_valid), .in_ready(in_ready), .x_bit(x_bit), .y_bit(y_bit),
    .load_en(load_en), .data_in_x(data_in_x), .data_in_y(data_in_y), .init(init),
    .data_out_z(data_out_z), .tx_ready(tx_ready), .z_bit(z_bit), .z_valid(z_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int cyc = 0, n_load, n_init, n_z, n_done, n_bad, n_fwd, n_gap6;
  int last_load, init_cyc, done_cyc, start_cyc;
  logic busy_after, prev_done = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (load_en) begin
      if (cyc - last_load == 6) n_gap6 = n_gap6 + 1;
      last_load = cyc;
      n_load = n_load + 1;
      if (!in_valid) n_bad = n_bad + 1;
    end
    if (init) begin n_init = n_init + 1; init_cyc = cyc; end
    if (z_valid) n_z = n_z + 1;
    if (done) begin n_done = n_done + 1; done_cyc = cyc; end
    if (prev_done) busy_after = busy;
    prev_done = done;
    if (start && !busy && rst) start_cyc = cyc;
    if (data_in_x !== x_bit || data_in_y !== y_bit || z_bit !== data_out_z) n_fwd = n_fwd + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    n_load = 0; n_init = 0; n_z = 0; n_done = 0; n_bad = 0; n_fwd = 0; n_gap6 = 0;
    last_load = -100; init_cyc = -1; done_cyc = -1; start_cyc = -1; busy_after = 1'b1;
  endtask

  typedef struct {
    int steps; bit toggle; int gap; bit dead; bit poke;
    int e_load; int e_init; int e_z; bit e_err;
  } vec_t;
  vec_t tbl[7];

  task automatic run_job(input vec_t v);
    int gap_left;
    gap_left = v.gap;
    clear();
    num_steps = 8'(v.steps);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2000 && n_done == 0; k++) begin
      in_valid = !v.toggle || (k % 2 == 0);
      x_bit = 1'($urandom); y_bit = 1'($urandom); data_out_z = 1'($urandom);
      tx_ready = !v.dead;
      if (gap_left > 0 && n_z >= 20) begin tx_ready = 1'b0; gap_left = gap_left - 1; end
      start = v.poke && busy && !in_ready && n_load > 0 && n_init == 0;
      tick();
    end
    start = 1'b0; in_valid = 1'b0; tx_ready = 1'b0;
    if (n_done == 0) $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    repeat (3) tick();
    chk("n_done", n_done, 1);
    chk("n_load", n_load, v.e_load);
    chk("n_init", n_init, v.e_init);
    chk("n_z", n_z, v.e_z);
    chk("err", int'(err), int'(v.e_err));
    chk("busy_after_done", int'(busy_after), 0);
    chk("busy_idle", int'(busy), 0);
    chk("load_without_valid", n_bad, 0);
    chk("forwarding", n_fwd, 0);
    if (v.steps > 0) chk("init_gap", init_cyc - last_load, 6);
    if (v.steps == 0) chk("zero_done_lat", done_cyc - start_cyc, 1);
    if (v.dead) chk("timeout_lat", done_cyc - init_cyc, 257);
    if (!v.toggle) chk("compute_gaps", n_gap6, v.steps > 0 ? v.steps - 1 : 0);
  endtask

  initial begin
    tbl[0] = '{1, 1'b0, 0,  1'b0, 1'b0, 16, 1, 64, 1'b0};
    tbl[1] = '{1, 1'b1, 0,  1'b0, 1'b0, 16, 1, 64, 1'b0};
    tbl[2] = '{3, 1'b0, 0,  1'b0, 1'b0, 48, 1, 64, 1'b0};
    tbl[3] = '{0, 1'b0, 0,  1'b0, 1'b0, 0,  0, 0,  1'b0};
    tbl[4] = '{1, 1'b0, 0,  1'b1, 1'b0, 16, 1, 0,  1'b1};
    tbl[5] = '{2, 1'b1, 10, 1'b0, 1'b0, 32, 1, 64, 1'b0};
    tbl[6] = '{1, 1'b0, 0,  1'b0, 1'b1, 16, 1, 64, 1'b0};
    clear();
    rst = 1'b0; start = 1'b0; num_steps = '0; in_valid = 1'b1; x_bit = 1'b0; y_bit = 1'b0;
    data_out_z = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", int'({busy, done, err, in_ready, init, z_valid, load_en}), 0);
    in_valid = 1'b0; tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) run_job(tbl[i]);
    clear();
    num_steps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; tx_ready = 1'b1;
    for (int k = 0; k < 50 && n_load < 7; k++) tick();
    chk("mid_load_bits", n_load, 7);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", int'({busy, done, err, in_ready, init, z_valid, load_en}), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("post_reset_init", n_init, 0);
    chk("post_reset_loads", n_load, 7);
    chk("post_reset_busy", int'(busy), 0);
    in_valid = 1'b0; tx_ready = 1'b0;
    tick();
    run_job(tbl[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
